ram_access_ctrl: RTL and testbench
==================================

Name: ram_access_ctrl

Overview:
- Memory controller between the core and the dual-port RAM (32-bit words, 1-cycle registered read, write through port A only).
- Port B is dedicated to instruction fetch.
- Port A is shared by the load/store unit (LSU) and the program loader (LDR). Loader has fixed priority.
- Performs load sign/zero extension, read-modify-write for byte/half stores, alignment/range checking, and same-word write→fetch forwarding.

Parameters:
- ADDR_W, 14, word-address width; RAM depth is 2**ADDR_W words. Byte-address limit is 4*2**ADDR_W.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request
- if_addr  in  32  fetch byte address
- if_rvalid  out  1  fetch response valid
- if_rdata  out  32  fetch instruction word
- if_err  out  1  fetch misaligned or out of range
- lsu_req  in  1  LSU request
- lsu_we  in  1  1=store, 0=load
- lsu_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- lsu_unsigned  in  1  zero-extend load
- lsu_addr  in  32  byte address
- lsu_wdata  in  32  store data, right-aligned
- lsu_ready  out  1  request accepted this cycle
- lsu_rvalid  out  1  response pulse (load data or store done)
- lsu_rdata  out  32  extended load data
- lsu_err  out  1  error flag, qualified by lsu_rvalid
- ldr_req  in  1  loader word write request
- ldr_addr  in  ADDR_W  word address
- ldr_wdata  in  32  word data
- ldr_ready  out  1  loader request accepted
- ram_addr_a  out  ADDR_W  port A word address
- ram_addr_b  out  ADDR_W  port B word address
- ram_wdata  out  32  write data
- ram_read_a_en  out  1  port A read enable
- ram_read_b_en  out  1  port B read enable
- ram_write_en  out  1  write enable (port A address)
- ram_rdata_a  in  32  port A read data
- ram_rdata_b  in  32  port B read data

Behaviour:
- Reset (async, rst_n=0):
  - FSM→IDLE. All registered outputs 0: if_rvalid, lsu_rvalid, lsu_err, if_err, lsu_rdata.
  - ram_write_en, ram_read_a_en, ram_read_b_en forced 0 while rst_n=0.
  - Reset mid-transaction drops it; no partial RMW write may occur.
- Port A FSM states: IDLE, LOAD, RMW.
- Acceptance in IDLE:
  - ldr_ready = ldr_req.
  - lsu_ready = lsu_req & ~ldr_req.
  - Outside IDLE both ready signals are 0. Requesters hold their request until ready.
- LDR accept: ram_write_en=1 in the accept cycle; stay IDLE. Back-to-back loader writes run at 1 word per cycle.
- LSU checks at accept:
  - Illegal size, half with addr[0]=1, word with addr[1:0]≠0, or addr ≥ 4*2**ADDR_W → no RAM enable.
  - Next cycle: lsu_rvalid=1, lsu_err=1, lsu_rdata=0.
- Load:
  - read_a_en at accept; → LOAD.
  - In LOAD, select lane by addr[1:0] and extend (sign unless lsu_unsigned); register.
  - lsu_rvalid pulses the cycle after LOAD (2 cycles after accept); → IDLE.
- Word store: write_en at accept; lsu_rvalid next cycle; stay IDLE.
- Byte/half store:
  - read_a_en at accept; → RMW.
  - In RMW, drive write_en with ram_rdata_a merged with the byte/half lane from lsu_wdata[7:0]/[15:0].
  - lsu_rvalid next cycle; → IDLE.
  - Address, size and data are latched at accept.
- Fetch (port B, never blocked):
  - read_b_en = if_req & aligned & in range.
  - if_rvalid one cycle after the request, with if_rdata = ram_rdata_b.
  - Misaligned or out-of-range fetch: if_rvalid and if_err next cycle, if_rdata=0. A new request is allowed every cycle.
- Forwarding: if a port-B read hits the same word as a port-A write in the same cycle, the RAM returns old data. The controller registers the write data and drives it on if_rdata instead.
- Simultaneous ldr_req and lsu_req: loader wins. LSU waits and is not starved once ldr_req deasserts.

Test Plan:
- Reset, then ldr writes 0x11223344 to word 5 → ldr_ready=1 that cycle. Word load at 0x14 → lsu_rvalid 2 cycles after accept, rdata=0x11223344, err=0.
- Byte load at 0x17 of word 0x80FF0000, signed → rdata=0xFFFFFF80. Same access unsigned → 0x00000080. Half load at 0x16 signed → 0xFFFF80FF.
- Byte store 0xAB at 0x15 over 0x11223344 → ready low during RMW. Subsequent load of 0x14 → 0x1122AB44. lsu_rvalid 2 cycles after accept.
- Half at 0x13, word at 0x02, size=11, addr=4*2**ADDR_W → each returns lsu_rvalid=1, err=1, rdata=0, and no RAM enable observed.
- Word store 0xDEADBEEF to 0x40 with fetch of 0x40 in the same cycle → if_rdata=0xDEADBEEF (forwarded). Fetch 0x42 → if_err=1.
- ldr_req and lsu_req together → ldr served first, LSU accepted the cycle ldr_req drops. Assert rst_n=0 during RMW → no ram_write_en, all valids 0, FSM in IDLE after release.

Source files
------------

// File: rtl/ram_access_ctrl_if.sv
// Core/loader/RAM-side signal bundle for the RAM access controller.
// The controller uses the slave view; the core, loader and RAM use the master view.
interface ram_access_ctrl_if #(
    parameter int ADDR_W = 14
);
    // Instruction fetch (port B)
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_rvalid;
    logic [31:0]       if_rdata;
    logic              if_err;

    // Load/store unit (port A)
    logic              lsu_req;
    logic              lsu_we;
    logic [1:0]        lsu_size;
    logic              lsu_unsigned;
    logic [31:0]       lsu_addr;
    logic [31:0]       lsu_wdata;
    logic              lsu_ready;
    logic              lsu_rvalid;
    logic [31:0]       lsu_rdata;
    logic              lsu_err;

    // Program loader (port A, priority)
    logic              ldr_req;
    logic [ADDR_W-1:0] ldr_addr;
    logic [31:0]       ldr_wdata;
    logic              ldr_ready;

    // Dual-port RAM
    logic [ADDR_W-1:0] ram_addr_a;
    logic [ADDR_W-1:0] ram_addr_b;
    logic [31:0]       ram_wdata;
    logic              ram_read_a_en;
    logic              ram_read_b_en;
    logic              ram_write_en;
    logic [31:0]       ram_rdata_a;
    logic [31:0]       ram_rdata_b;

    modport slave (
        input  if_req, if_addr,
        output if_rvalid, if_rdata, if_err,
        input  lsu_req, lsu_we, lsu_size, lsu_unsigned, lsu_addr, lsu_wdata,
        output lsu_ready, lsu_rvalid, lsu_rdata, lsu_err,
        input  ldr_req, ldr_addr, ldr_wdata,
        output ldr_ready,
        output ram_addr_a, ram_addr_b, ram_wdata, ram_read_a_en, ram_read_b_en, ram_write_en,
        input  ram_rdata_a, ram_rdata_b
    );

    modport master (
        output if_req, if_addr,
        input  if_rvalid, if_rdata, if_err,
        output lsu_req, lsu_we, lsu_size, lsu_unsigned, lsu_addr, lsu_wdata,
        input  lsu_ready, lsu_rvalid, lsu_rdata, lsu_err,
        output ldr_req, ldr_addr, ldr_wdata,
        input  ldr_ready,
        input  ram_addr_a, ram_addr_b, ram_wdata, ram_read_a_en, ram_read_b_en, ram_write_en,
        output ram_rdata_a, ram_rdata_b
    );
endinterface

// File: rtl/ram_access_ctrl.sv
// Port-A arbiter/FSM (loader over LSU, load extension, sub-word RMW) plus
// port-B fetch path with same-word write-to-fetch forwarding.
module ram_access_ctrl #(
    parameter int ADDR_W = 14
) (
    input logic            clk,
    input logic            rst_n,
    ram_access_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, RMW} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W+1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              lsu_rvalid_q, lsu_rvalid_d;
    logic              lsu_err_q, lsu_err_d;
    logic [31:0]       lsu_rdata_q, lsu_rdata_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              if_err_q, if_err_d;
    logic              fwd_hit_q, fwd_hit_d;
    logic [31:0]       fwd_data_q, fwd_data_d;

    logic              lsu_bad, if_ok, wr_en, rd_a_en;
    logic [ADDR_W-1:0] addr_a;
    logic [31:0]       wdata, merged, load_ext;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;

    assign lsu_bad = (bus.lsu_size == 2'b11)
                   | ((bus.lsu_size == 2'b01) & bus.lsu_addr[0])
                   | ((bus.lsu_size == 2'b10) & (|bus.lsu_addr[1:0]))
                   | (|bus.lsu_addr[31:ADDR_W+2]);

    assign if_ok = bus.if_req & (bus.if_addr[1:0] == 2'b00) & ~(|bus.if_addr[31:ADDR_W+2]);

    // Lane select on the latched byte address; ram_rdata_a is valid in LOAD/RMW.
    always_comb begin
        byte_v   = bus.ram_rdata_a[{addr_q[1:0], 3'b000} +: 8];
        half_v   = bus.ram_rdata_a[{addr_q[1], 4'b0000} +: 16];
        load_ext = bus.ram_rdata_a;
        merged   = bus.ram_rdata_a;
        case (size_q)
            2'b00: begin
                load_ext = {{24{byte_v[7] & ~uns_q}}, byte_v};
                merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            end
            2'b01: begin
                load_ext = {{16{half_v[15] & ~uns_q}}, half_v};
                merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            end
            default: ;
        endcase
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        size_d        = size_q;
        uns_d         = uns_q;
        wdata_d       = wdata_q;
        lsu_rvalid_d  = 1'b0;
        lsu_err_d     = 1'b0;
        lsu_rdata_d   = '0;
        wr_en         = 1'b0;
        rd_a_en       = 1'b0;
        addr_a        = addr_q[ADDR_W+1:2];
        wdata         = merged;
        bus.ldr_ready = 1'b0;
        bus.lsu_ready = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.ldr_req) begin
                    bus.ldr_ready = 1'b1;
                    wr_en         = 1'b1;
                    addr_a        = bus.ldr_addr;
                    wdata         = bus.ldr_wdata;
                end else if (bus.lsu_req) begin
                    bus.lsu_ready = 1'b1;
                    addr_d        = bus.lsu_addr[ADDR_W+1:0];
                    size_d        = bus.lsu_size;
                    uns_d         = bus.lsu_unsigned;
                    wdata_d       = bus.lsu_wdata;
                    addr_a        = bus.lsu_addr[ADDR_W+1:2];
                    wdata         = bus.lsu_wdata;
                    if (lsu_bad) begin
                        lsu_rvalid_d = 1'b1;
                        lsu_err_d    = 1'b1;
                    end else if (!bus.lsu_we) begin
                        rd_a_en = 1'b1;
                        state_d = LOAD;
                    end else if (bus.lsu_size == 2'b10) begin
                        wr_en        = 1'b1;
                        lsu_rvalid_d = 1'b1;
                    end else begin
                        rd_a_en = 1'b1;
                        state_d = RMW;
                    end
                end
            end
            LOAD: begin
                lsu_rvalid_d = 1'b1;
                lsu_rdata_d  = load_ext;
                state_d      = IDLE;
            end
            RMW: begin
                wr_en        = 1'b1;
                lsu_rvalid_d = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A port-B read of the word being written returns stale data; substitute the write data.
        if_rvalid_d = bus.if_req;
        if_err_d    = bus.if_req & ~if_ok;
        fwd_hit_d   = if_ok & wr_en & (addr_a == bus.if_addr[ADDR_W+1:2]);
        fwd_data_d  = wdata;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            wdata_q      <= '0;
            lsu_rvalid_q <= 1'b0;
            lsu_err_q    <= 1'b0;
            lsu_rdata_q  <= '0;
            if_rvalid_q  <= 1'b0;
            if_err_q     <= 1'b0;
            fwd_hit_q    <= 1'b0;
            fwd_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            wdata_q      <= wdata_d;
            lsu_rvalid_q <= lsu_rvalid_d;
            lsu_err_q    <= lsu_err_d;
            lsu_rdata_q  <= lsu_rdata_d;
            if_rvalid_q  <= if_rvalid_d;
            if_err_q     <= if_err_d;
            fwd_hit_q    <= fwd_hit_d;
            fwd_data_q   <= fwd_data_d;
        end
    end

    // Enables are gated by rst_n so a reset mid-RMW cannot leak a partial write.
    assign bus.ram_write_en  = wr_en & rst_n;
    assign bus.ram_read_a_en = rd_a_en & rst_n;
    assign bus.ram_read_b_en = if_ok & rst_n;
    assign bus.ram_addr_a    = addr_a;
    assign bus.ram_addr_b    = bus.if_addr[ADDR_W+1:2];
    assign bus.ram_wdata     = wdata;

    assign bus.lsu_rvalid = lsu_rvalid_q;
    assign bus.lsu_err    = lsu_err_q;
    assign bus.lsu_rdata  = lsu_rdata_q;
    assign bus.if_rvalid  = if_rvalid_q;
    assign bus.if_err     = if_err_q;
    assign bus.if_rdata   = (!if_rvalid_q || if_err_q) ? '0
                          : (fwd_hit_q ? fwd_data_q : bus.ram_rdata_b);
endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed self-checking bench for ram_access_ctrl with a behavioural
// dual-port RAM (1-cycle registered read, read-during-write returns old data).
module tb_ram_access_ctrl;
    localparam int ADDR_W = 14;

    logic clk = 1'b0;
    logic rst_n;
    int   tests  = 0;
    int   failed = 0;

    ram_access_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    ram_access_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    always @(posedge clk) begin
        if (bus.ram_read_a_en) bus.ram_rdata_a <= mem[bus.ram_addr_a];
        if (bus.ram_read_b_en) bus.ram_rdata_b <= mem[bus.ram_addr_b];
        if (bus.ram_write_en)  mem[bus.ram_addr_a] <= bus.ram_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Issues one LSU request, waits for acceptance, then for lsu_rvalid.
    // lat counts cycles from accept to rvalid (0 = never). With hold=1 the
    // request stays up one extra cycle and busy_ready samples lsu_ready there.
    task automatic lsu_op(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd, input bit hold,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output logic en_seen, output logic busy_ready);
        bit acc = 0;
        lat = 0; rdata = 'x; err = 'x; en_seen = 0; busy_ready = 'x;
        bus.lsu_req = 1; bus.lsu_we = we; bus.lsu_size = size;
        bus.lsu_unsigned = uns; bus.lsu_addr = addr; bus.lsu_wdata = wd;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            en_seen |= bus.ram_write_en | bus.ram_read_a_en;
            if (bus.lsu_ready) begin acc = 1; break; end
            cyc();
        end
        cyc();
        if (!hold) bus.lsu_req = 0;
        if (acc) begin
            for (int n = 1; n <= 10; n++) begin
                @(negedge clk);
                en_seen |= bus.ram_write_en | bus.ram_read_a_en;
                if (n == 1) busy_ready = bus.lsu_ready;
                if (bus.lsu_rvalid) begin lat = n; rdata = bus.lsu_rdata; err = bus.lsu_err; break; end
                cyc();
                bus.lsu_req = 0;
            end
        end
        bus.lsu_req = 0;
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er, en, br;
        int          lat;

        rst_n = 0;
        bus.if_req = 1; bus.if_addr = 32'h14;
        bus.lsu_req = 0; bus.lsu_we = 0; bus.lsu_size = 0; bus.lsu_unsigned = 0;
        bus.lsu_addr = 0; bus.lsu_wdata = 0;
        bus.ldr_req = 1; bus.ldr_addr = 5; bus.ldr_wdata = 32'hFFFF_FFFF;

        // Reset: requests present but all enables and valids held low.
        repeat (2) cyc();
        @(negedge clk);
        check("rst_write_en", bus.ram_write_en, 0);
        check("rst_read_b_en", bus.ram_read_b_en, 0);
        check("rst_if_rvalid", bus.if_rvalid, 0);
        check("rst_if_err", bus.if_err, 0);
        check("rst_lsu_rvalid", bus.lsu_rvalid, 0);
        check("rst_lsu_err", bus.lsu_err, 0);
        check("rst_lsu_rdata", bus.lsu_rdata, 0);
        cyc();
        bus.if_req = 0; bus.ldr_req = 0;
        rst_n = 1;
        cyc();

        // Loader word write.
        bus.ldr_req = 1; bus.ldr_addr = 5; bus.ldr_wdata = 32'h1122_3344;
        @(negedge clk);
        check("ldr_ready", bus.ldr_ready, 1);
        check("ldr_write_en", bus.ram_write_en, 1);
        check("ldr_addr_a", bus.ram_addr_a, 5);
        cyc();
        bus.ldr_req = 0;

        lsu_op(0, 2'b10, 0, 32'h14, 0, 0, rd, er, lat, en, br);
        check("ldw_lat", lat, 2);
        check("ldw_rdata", rd, 32'h1122_3344);
        check("ldw_err", er, 0);

        // Sign/zero extension on 0x80FF0000.
        bus.ldr_req = 1; bus.ldr_addr = 5; bus.ldr_wdata = 32'h80FF_0000;
        cyc();
        bus.ldr_req = 0;
        lsu_op(0, 2'b00, 0, 32'h17, 0, 0, rd, er, lat, en, br);
        check("ldb_signed", rd, 32'hFFFF_FF80);
        lsu_op(0, 2'b00, 1, 32'h17, 0, 0, rd, er, lat, en, br);
        check("ldb_unsigned", rd, 32'h0000_0080);
        lsu_op(0, 2'b01, 0, 32'h16, 0, 0, rd, er, lat, en, br);
        check("ldh_signed", rd, 32'hFFFF_80FF);
        lsu_op(0, 2'b01, 1, 32'h14, 0, 0, rd, er, lat, en, br);
        check("ldh_lo_unsigned", rd, 32'h0000_0000);

        // Byte store via RMW.
        bus.ldr_req = 1; bus.ldr_addr = 5; bus.ldr_wdata = 32'h1122_3344;
        cyc();
        bus.ldr_req = 0;
        lsu_op(1, 2'b00, 0, 32'h15, 32'h0000_00AB, 1, rd, er, lat, en, br);
        check("stb_busy_ready", br, 0);
        check("stb_lat", lat, 2);
        check("stb_err", er, 0);
        lsu_op(0, 2'b10, 0, 32'h14, 0, 0, rd, er, lat, en, br);
        check("stb_readback", rd, 32'h1122_AB44);
        check("stb_readback_lat", lat, 2);

        // Half store on upper lane.
        lsu_op(1, 2'b01, 0, 32'h22, 32'h1234_5678, 0, rd, er, lat, en, br);
        lsu_op(0, 2'b10, 0, 32'h20, 0, 0, rd, er, lat, en, br);
        check("sth_readback", rd[31:16], 32'h5678);

        // Error cases: next-cycle response, err=1, rdata=0, no RAM enable.
        lsu_op(0, 2'b01, 0, 32'h13, 0, 0, rd, er, lat, en, br);
        check("err_half_lat", lat, 1);
        check("err_half_err", er, 1);
        check("err_half_rdata", rd, 0);
        check("err_half_en", en, 0);
        lsu_op(0, 2'b10, 0, 32'h02, 0, 0, rd, er, lat, en, br);
        check("err_word_err", er, 1);
        check("err_word_en", en, 0);
        lsu_op(1, 2'b11, 0, 32'h20, 32'h55, 0, rd, er, lat, en, br);
        check("err_size_lat", lat, 1);
        check("err_size_err", er, 1);
        check("err_size_en", en, 0);
        lsu_op(0, 2'b10, 0, 32'h0001_0000, 0, 0, rd, er, lat, en, br);
        check("err_range_err", er, 1);
        check("err_range_rdata", rd, 0);
        check("err_range_en", en, 0);

        // Plain fetch.
        bus.if_req = 1; bus.if_addr = 32'h14;
        @(negedge clk);
        check("if_read_b_en", bus.ram_read_b_en, 1);
        check("if_addr_b", bus.ram_addr_b, 5);
        cyc();
        bus.if_req = 0;
        @(negedge clk);
        check("if_rvalid", bus.if_rvalid, 1);
        check("if_rdata", bus.if_rdata, 32'h1122_AB44);
        check("if_err_ok", bus.if_err, 0);
        cyc();

        // Word store and fetch to the same word in the same cycle: forwarded.
        bus.lsu_req = 1; bus.lsu_we = 1; bus.lsu_size = 2'b10;
        bus.lsu_addr = 32'h40; bus.lsu_wdata = 32'hDEAD_BEEF;
        bus.if_req = 1; bus.if_addr = 32'h40;
        @(negedge clk);
        check("fwd_lsu_ready", bus.lsu_ready, 1);
        check("fwd_write_en", bus.ram_write_en, 1);
        cyc();
        bus.lsu_req = 0; bus.if_addr = 32'h42;
        @(negedge clk);
        check("fwd_if_rdata", bus.if_rdata, 32'hDEAD_BEEF);
        check("fwd_if_err", bus.if_err, 0);
        check("fwd_lsu_rvalid", bus.lsu_rvalid, 1);
        check("mis_read_b_en", bus.ram_read_b_en, 0);
        cyc();
        bus.if_req = 0;
        @(negedge clk);
        check("mis_if_rvalid", bus.if_rvalid, 1);
        check("mis_if_err", bus.if_err, 1);
        check("mis_if_rdata", bus.if_rdata, 0);
        cyc();
        lsu_op(0, 2'b10, 0, 32'h40, 0, 0, rd, er, lat, en, br);
        check("fwd_readback", rd, 32'hDEAD_BEEF);

        // Loader priority over a simultaneous LSU request.
        bus.ldr_req = 1; bus.ldr_addr = 7; bus.ldr_wdata = 32'hA5A5_0007;
        bus.lsu_req = 1; bus.lsu_we = 0; bus.lsu_size = 2'b10; bus.lsu_unsigned = 0;
        bus.lsu_addr = 32'h14;
        @(negedge clk);
        check("prio_ldr_ready", bus.ldr_ready, 1);
        check("prio_lsu_wait", bus.lsu_ready, 0);
        cyc();
        bus.ldr_addr = 8; bus.ldr_wdata = 32'hA5A5_0008;
        @(negedge clk);
        check("prio_lsu_wait2", bus.lsu_ready, 0);
        cyc();
        bus.ldr_req = 0;
        @(negedge clk);
        check("prio_lsu_accept", bus.lsu_ready, 1);
        cyc();
        bus.lsu_req = 0;
        cyc();
        @(negedge clk);
        check("prio_lsu_rvalid", bus.lsu_rvalid, 1);
        check("prio_lsu_rdata", bus.lsu_rdata, 32'h1122_AB44);
        cyc();
        lsu_op(0, 2'b10, 0, 32'h20, 0, 0, rd, er, lat, en, br);
        lsu_op(0, 2'b10, 0, 32'h1C, 0, 0, rd, er, lat, en, br);
        check("prio_ldr_word7", rd, 32'hA5A5_0007);

        // Reset during RMW: no write, outputs cleared, FSM idle afterwards.
        bus.lsu_req = 1; bus.lsu_we = 1; bus.lsu_size = 2'b00;
        bus.lsu_addr = 32'h14; bus.lsu_wdata = 32'h55;
        @(negedge clk);
        check("rmw_rst_accept", bus.lsu_ready, 1);
        cyc();
        bus.lsu_req = 0;
        rst_n = 0;
        @(negedge clk);
        check("rmw_rst_write_en", bus.ram_write_en, 0);
        check("rmw_rst_lsu_rvalid", bus.lsu_rvalid, 0);
        check("rmw_rst_if_rvalid", bus.if_rvalid, 0);
        cyc();
        rst_n = 1;
        cyc();
        @(negedge clk);
        check("rmw_post_rvalid", bus.lsu_rvalid, 0);
        cyc();
        lsu_op(0, 2'b10, 0, 32'h14, 0, 0, rd, er, lat, en, br);
        check("rmw_post_lat", lat, 2);
        check("rmw_post_data", rd, 32'h1122_AB44);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
